// File: rtl/voice_allocator.sv
// voice_allocator
//   Decodes 16-bit note commands written over the avs_s0 slave into a bank of
//   N_VOICES voice registers (gate / note / velocity) and hands out voices in
//   a polyphonic fashion: a start of an already-playing note retriggers it, a
//   start of a new note takes the lowest free voice, and a start on a full bank
//   either steals the oldest voice or is dropped (see build option below).
//
//   Build option: VOICE_ALLOC_STEAL_EN
//     defined   - full bank: steal the oldest voice (lowest index on a tie)
//     undefined - full bank: drop the start and bump the saturating drop count
//
//   Ports
//     clk               system clock
//     reset             asynchronous, active-low reset
//     avs_s0_write      command strobe; writedata[15]=start, [14:8]=note,
//                       [7:0]=velocity, [31:16] ignored
//     avs_s0_read       status read strobe
//     avs_s0_readdata   registered status: [15:0] active mask, [23:16] drops
//     o_gate            per-voice gate
//     o_note            per-voice note, voice i at [i*NOTE_W +: NOTE_W]
//     o_velocity        per-voice velocity, voice i at [i*VEL_W +: VEL_W]
//     o_trig            one-cycle pulse on start, retrigger or steal
//
//   Handshake: a command is taken on every rising clk edge with avs_s0_write=1
//   (no back-pressure); a status read is taken on every edge with
//   avs_s0_read=1 and its data appears on avs_s0_readdata after that edge.
module voice_allocator #(
    parameter int N_VOICES = 8,
    parameter int NOTE_W   = 7,
    parameter int VEL_W    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         avs_s0_write,
    input  logic [31:0]                  avs_s0_writedata,
    input  logic                         avs_s0_read,
    output logic [31:0]                  avs_s0_readdata,
    output logic [N_VOICES-1:0]          o_gate,
    output logic [N_VOICES*NOTE_W-1:0]   o_note,
    output logic [N_VOICES*VEL_W-1:0]    o_velocity,
    output logic [N_VOICES-1:0]          o_trig
);

    localparam int AGE_W = $clog2(N_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(N_VOICES - 1);

    logic [N_VOICES-1:0] gate_q, gate_d;
    logic [N_VOICES-1:0] trig_q, trig_d;
    logic [NOTE_W-1:0]   note_q [N_VOICES];
    logic [NOTE_W-1:0]   note_d [N_VOICES];
    logic [VEL_W-1:0]    vel_q  [N_VOICES];
    logic [VEL_W-1:0]    vel_d  [N_VOICES];
    logic [AGE_W-1:0]    age_q  [N_VOICES];
    logic [AGE_W-1:0]    age_d  [N_VOICES];
    logic [7:0]          drop_q, drop_d;
    logic [31:0]         rdata_q, rdata_d;

    // Command fields
    logic                cmd_start;
    logic [6:0]          cmd_note_raw;
    logic [NOTE_W-1:0]   cmd_note;
    logic [VEL_W-1:0]    cmd_vel;
    logic                unused_hi;

    assign cmd_start    = avs_s0_writedata[15];
    assign cmd_note_raw = avs_s0_writedata[14:8];
    assign cmd_note     = NOTE_W'(cmd_note_raw);
    assign cmd_vel      = VEL_W'(avs_s0_writedata[7:0]);
    assign unused_hi    = ^avs_s0_writedata[31:16];

    // Voice search results
    logic               hit, free;
    logic [AGE_W-1:0]   hit_idx, free_idx, alloc_idx;
    logic               do_alloc;
`ifdef VOICE_ALLOC_STEAL_EN
    logic [AGE_W-1:0]   old_idx, old_age;
`endif

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        // At most one gated voice holds a given note, so the last match wins
        // without ambiguity.
        for (int i = 0; i < N_VOICES; i++) begin
            if (gate_q[i] && note_q[i] == cmd_note) begin
                hit     = 1'b1;
                hit_idx = AGE_W'(i);
            end
        end
        // Scan downwards so the lowest free index is the one left standing.
        for (int i = N_VOICES - 1; i >= 0; i--) begin
            if (!gate_q[i]) begin
                free     = 1'b1;
                free_idx = AGE_W'(i);
            end
        end
`ifdef VOICE_ALLOC_STEAL_EN
        // Strict '>' keeps the lowest index among voices of equal age.
        old_idx = '0;
        old_age = age_q[0];
        for (int i = 1; i < N_VOICES; i++) begin
            if (age_q[i] > old_age) begin
                old_age = age_q[i];
                old_idx = AGE_W'(i);
            end
        end
`endif
    end

    always_comb begin
        gate_d    = gate_q;
        trig_d    = '0;
        note_d    = note_q;
        vel_d     = vel_q;
        age_d     = age_q;
        drop_d    = drop_q;
        rdata_d   = avs_s0_read ? {8'd0, drop_q, 16'(gate_q)} : rdata_q;
        do_alloc  = 1'b0;
        alloc_idx = free_idx;

        if (avs_s0_write) begin
            if (cmd_start) begin
                if (hit) begin
                    vel_d[hit_idx]  = cmd_vel;
                    trig_d[hit_idx] = 1'b1;
                end else if (free) begin
                    do_alloc = 1'b1;
                end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                    do_alloc  = 1'b1;
                    alloc_idx = old_idx;
`else
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
`endif
                end
            end else if (cmd_note_raw == 7'h7F) begin
                // STOP_ALL
                gate_d = '0;
                for (int i = 0; i < N_VOICES; i++) begin
                    age_d[i] = '0;
                end
            end else if (hit) begin
                gate_d[hit_idx] = 1'b0;
                age_d[hit_idx]  = '0;
            end
        end

        if (do_alloc) begin
            for (int i = 0; i < N_VOICES; i++) begin
                if (AGE_W'(i) == alloc_idx) begin
                    gate_d[i] = 1'b1;
                    trig_d[i] = 1'b1;
                    note_d[i] = cmd_note;
                    vel_d[i]  = cmd_vel;
                    age_d[i]  = '0;
                end else if (gate_q[i] && age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gate_q  <= '0;
            trig_q  <= '0;
            drop_q  <= '0;
            rdata_q <= '0;
            for (int i = 0; i < N_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            gate_q  <= gate_d;
            trig_q  <= trig_d;
            drop_q  <= drop_d;
            rdata_q <= rdata_d;
            note_q  <= note_d;
            vel_q   <= vel_d;
            age_q   <= age_d;
        end
    end

    for (genvar g = 0; g < N_VOICES; g++) begin : g_pack
        assign o_note[g*NOTE_W +: NOTE_W]  = note_q[g];
        assign o_velocity[g*VEL_W +: VEL_W] = vel_q[g];
    end

    assign o_gate          = gate_q;
    assign o_trig          = trig_q;
    assign avs_s0_readdata = rdata_q;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

    localparam int N = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            avs_s0_write = 1'b0;
    logic [31:0]     avs_s0_writedata = '0;
    logic            avs_s0_read = 1'b0;
    logic [31:0]     avs_s0_readdata;
    logic [N-1:0]    o_gate;
    logic [N*7-1:0]  o_note;
    logic [N*8-1:0]  o_velocity;
    logic [N-1:0]    o_trig;

    int total = 0;
    int bad   = 0;

    voice_allocator #(.N_VOICES(N), .NOTE_W(7), .VEL_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .avs_s0_write     (avs_s0_write),
        .avs_s0_writedata (avs_s0_writedata),
        .avs_s0_read      (avs_s0_read),
        .avs_s0_readdata  (avs_s0_readdata),
        .o_gate           (o_gate),
        .o_note           (o_note),
        .o_velocity       (o_velocity),
        .o_trig           (o_trig)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Age of an active voice = allocations since it was loaded, capped at N-1.
    bit          m_gate  [N];
    int          m_note  [N];
    int          m_vel   [N];
    int          m_stamp [N];
    bit          m_trig  [N];
    int          m_cnt;
    int          m_drop;
    logic [31:0] m_rd;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_stamp[i] = 0; m_trig[i] = 0;
        end
        m_cnt = 0; m_drop = 0; m_rd = '0;
    endtask

    function automatic logic [N-1:0] exp_gate();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_gate[i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_trig();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_trig[i];
        return v;
    endfunction

    function automatic logic [N*7-1:0] exp_notes();
        logic [N*7-1:0] v;
        for (int i = 0; i < N; i++) v[i*7 +: 7] = 7'(m_note[i]);
        return v;
    endfunction

    function automatic logic [N*8-1:0] exp_vels();
        logic [N*8-1:0] v;
        for (int i = 0; i < N; i++) v[i*8 +: 8] = 8'(m_vel[i]);
        return v;
    endfunction

    task automatic model_step(input logic wr, input logic [31:0] data, input logic rd);
        int n, v, hit, slot, best, a;
        if (rd) m_rd = {8'd0, 8'(m_drop), 16'(exp_gate())};
        for (int i = 0; i < N; i++) m_trig[i] = 0;
        if (!wr) return;
        n = int'(data[14:8]);
        v = int'(data[7:0]);
        hit = -1;
        for (int i = 0; i < N; i++) if (m_gate[i] && m_note[i] == n) hit = i;
        if (data[15]) begin
            if (hit >= 0) begin
                m_vel[hit] = v; m_trig[hit] = 1;
            end else begin
                slot = -1;
                for (int i = N - 1; i >= 0; i--) if (!m_gate[i]) slot = i;
                if (slot < 0) begin
`ifdef VOICE_ALLOC_STEAL_EN
                    best = -1;
                    for (int i = 0; i < N; i++) begin
                        a = (m_cnt - m_stamp[i] > N - 1) ? N - 1 : m_cnt - m_stamp[i];
                        if (a > best) begin best = a; slot = i; end
                    end
`else
                    if (m_drop < 255) m_drop++;
`endif
                end
                if (slot >= 0) begin
                    m_cnt++;
                    m_stamp[slot] = m_cnt;
                    m_gate[slot] = 1; m_note[slot] = n; m_vel[slot] = v; m_trig[slot] = 1;
                end
            end
        end else if (n == 127) begin
            for (int i = 0; i < N; i++) m_gate[i] = 0;
        end else if (hit >= 0) begin
            m_gate[hit] = 0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic wr, input logic [31:0] data, input logic rd);
        @(negedge clk);
        avs_s0_write = wr; avs_s0_writedata = data; avs_s0_read = rd;
        @(posedge clk);
        model_step(wr, data, rd);
        #1;
        avs_s0_write = 1'b0; avs_s0_read = 1'b0;
    endtask

    function automatic logic [31:0] start_cmd(input int note, input int vel);
        return 32'h8000 | (32'(note) << 8) | 32'(vel & 8'hFF);
    endfunction

    function automatic logic [31:0] stop_cmd(input int note);
        return 32'(note) << 8;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        model_reset();
        #1;
        total++; if (o_gate !== '0) begin bad++; $display("FAIL reset_gate got=%h exp=0", o_gate); end
        total++; if (o_trig !== '0) begin bad++; $display("FAIL reset_trig got=%h exp=0", o_trig); end
        total++; if (o_note !== '0 || o_velocity !== '0) begin bad++; $display("FAIL reset_regs note=%h vel=%h exp=0", o_note, o_velocity); end
        total++; if (avs_s0_readdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", avs_s0_readdata); end
    endtask

    task automatic test_single_start();
        drive(1'b1, 32'h0000C500, 1'b0);
        total++; if (o_gate !== 8'h01) begin bad++; $display("FAIL start_gate got=%h exp=01", o_gate); end
        total++; if (o_note[6:0] !== 7'd69) begin bad++; $display("FAIL start_note got=%0d exp=69", o_note[6:0]); end
        total++; if (o_velocity[7:0] !== 8'h00) begin bad++; $display("FAIL start_vel got=%h exp=00", o_velocity[7:0]); end
        total++; if (o_trig !== 8'h01) begin bad++; $display("FAIL start_trig got=%h exp=01", o_trig); end
        drive(1'b0, 32'h0, 1'b1);
        total++; if (o_trig !== 8'h00) begin bad++; $display("FAIL start_trig_clear got=%h exp=00", o_trig); end
        total++; if (avs_s0_readdata !== 32'h00000001) begin bad++; $display("FAIL start_rdata got=%h exp=00000001", avs_s0_readdata); end
    endtask

    task automatic test_retrigger();
        drive(1'b1, 32'h0000C540, 1'b0);
        total++; if (o_gate !== 8'h01) begin bad++; $display("FAIL retrig_gate got=%h exp=01", o_gate); end
        total++; if (o_velocity[7:0] !== 8'h40) begin bad++; $display("FAIL retrig_vel got=%h exp=40", o_velocity[7:0]); end
        total++; if (o_trig !== 8'h01) begin bad++; $display("FAIL retrig_trig got=%h exp=01", o_trig); end
        drive(1'b0, 32'h0, 1'b1);
        total++; if (avs_s0_readdata !== 32'h00000001) begin bad++; $display("FAIL retrig_rdata got=%h exp=00000001", avs_s0_readdata); end
    endtask

    task automatic test_stop();
        drive(1'b1, 32'h00004900, 1'b0);
        total++; if (o_gate !== 8'h01 || o_trig !== 8'h00) begin bad++; $display("FAIL stop_absent gate=%h trig=%h exp=01/00", o_gate, o_trig); end
        drive(1'b1, 32'h00004500, 1'b0);
        total++; if (o_gate !== 8'h00) begin bad++; $display("FAIL stop_gate got=%h exp=00", o_gate); end
        total++; if (o_note[6:0] !== 7'd69 || o_velocity[7:0] !== 8'h40) begin bad++; $display("FAIL stop_keep note=%0d vel=%h exp=69/40", o_note[6:0], o_velocity[7:0]); end
        drive(1'b0, 32'h0, 1'b1);
        total++; if (avs_s0_readdata !== 32'h00000000) begin bad++; $display("FAIL stop_rdata got=%h exp=0", avs_s0_readdata); end
        // readdata must hold while no read is issued, even as state changes
        drive(1'b1, start_cmd(50, 1), 1'b0);
        total++; if (avs_s0_readdata !== 32'h00000000) begin bad++; $display("FAIL rdata_hold got=%h exp=0", avs_s0_readdata); end
    endtask

    task automatic test_full_bank();
        drive(1'b1, 32'h00007F00, 1'b0);
        for (int k = 0; k < 8; k++) drive(1'b1, start_cmd(60 + k, 10 + k), 1'b0);
        total++; if (o_gate !== 8'hFF) begin bad++; $display("FAIL full_gate got=%h exp=FF", o_gate); end
        drive(1'b1, start_cmd(68, 99), 1'b1);
`ifdef VOICE_ALLOC_STEAL_EN
        total++; if (o_note[6:0] !== 7'd68 || o_trig !== 8'h01) begin bad++; $display("FAIL steal_v0 note=%0d trig=%h exp=68/01", o_note[6:0], o_trig); end
        drive(1'b0, 32'h0, 1'b1);
        total++; if (avs_s0_readdata !== 32'h000000FF) begin bad++; $display("FAIL steal_rdata got=%h exp=000000FF", avs_s0_readdata); end
`else
        total++; if (o_note[6:0] !== 7'd60 || o_trig !== 8'h00) begin bad++; $display("FAIL drop_v0 note=%0d trig=%h exp=60/00", o_note[6:0], o_trig); end
        // the read shared an edge with the dropped write: pre-write drop count
        total++; if (avs_s0_readdata !== 32'h000000FF) begin bad++; $display("FAIL drop_pre_rdata got=%h exp=000000FF", avs_s0_readdata); end
        drive(1'b0, 32'h0, 1'b1);
        total++; if (avs_s0_readdata !== 32'h000100FF) begin bad++; $display("FAIL drop_rdata got=%h exp=000100FF", avs_s0_readdata); end
`endif
    endtask

    task automatic test_lowest_free();
        drive(1'b1, 32'h00007F00, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b1, start_cmd(60 + k, 20), 1'b0);
        drive(1'b1, stop_cmd(61), 1'b0);
        drive(1'b1, stop_cmd(62), 1'b0);
        total++; if (o_gate !== 8'h19) begin bad++; $display("FAIL free_gate got=%h exp=19", o_gate); end
        drive(1'b1, start_cmd(65, 33), 1'b0);
        total++; if (o_note[13:7] !== 7'd65 || o_trig !== 8'h02 || o_gate !== 8'h1B) begin
            bad++; $display("FAIL free_v1 note=%0d trig=%h gate=%h exp=65/02/1B", o_note[13:7], o_trig, o_gate);
        end
    endtask

    task automatic test_stop_all();
        drive(1'b1, 32'h00007F00, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b1, start_cmd(40 + k, 7), 1'b0);
        drive(1'b1, 32'h00007F00, 1'b0);
        total++; if (o_gate !== 8'h00 || o_trig !== 8'h00) begin bad++; $display("FAIL stopall gate=%h trig=%h exp=00/00", o_gate, o_trig); end
        drive(1'b1, start_cmd(127, 5), 1'b0);
        total++; if (o_gate !== 8'h01 || o_note[6:0] !== 7'd127) begin bad++; $display("FAIL start127 gate=%h note=%0d exp=01/127", o_gate, o_note[6:0]); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic        wr, rd;
        for (int it = 0; it < 500; it++) begin
            wr = ($urandom_range(0, 9) < 8);
            rd = $urandom_range(0, 1);
            d  = {$urandom} & 32'hFFFF00FF;
            d[14:8] = ($urandom_range(0, 15) == 0) ? 7'd127 : 7'(60 + $urandom_range(0, 11));
            d[15]   = ($urandom_range(0, 9) < 6);
            drive(wr, d, rd);
            total++; if (o_gate !== exp_gate()) begin bad++; $display("FAIL rnd_gate it=%0d got=%h exp=%h", it, o_gate, exp_gate()); end
            total++; if (o_trig !== exp_trig()) begin bad++; $display("FAIL rnd_trig it=%0d got=%h exp=%h", it, o_trig, exp_trig()); end
            total++; if (o_note !== exp_notes()) begin bad++; $display("FAIL rnd_note it=%0d got=%h exp=%h", it, o_note, exp_notes()); end
            total++; if (o_velocity !== exp_vels()) begin bad++; $display("FAIL rnd_vel it=%0d got=%h exp=%h", it, o_velocity, exp_vels()); end
            total++; if (avs_s0_readdata !== m_rd) begin bad++; $display("FAIL rnd_rdata it=%0d got=%h exp=%h", it, avs_s0_readdata, m_rd); end
        end
    endtask

`ifndef VOICE_ALLOC_STEAL_EN
    task automatic test_drop_saturate();
        drive(1'b1, 32'h00007F00, 1'b0);
        for (int k = 0; k < 8; k++) drive(1'b1, start_cmd(20 + k, 1), 1'b0);
        for (int k = 0; k < 270; k++) drive(1'b1, start_cmd(100, 1), 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        total++; if (avs_s0_readdata !== 32'h00FF00FF) begin bad++; $display("FAIL drop_sat got=%h exp=00FF00FF", avs_s0_readdata); end
    endtask
`endif

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) drive(1'b1, start_cmd(70 + k, 9), 1'b1);
        @(negedge clk);
        avs_s0_write = 1'b1; avs_s0_writedata = start_cmd(90, 3);
        #2 reset = 1'b0;
        #1;
        total++; if (o_gate !== '0 || o_trig !== '0) begin bad++; $display("FAIL midrst_gate gate=%h trig=%h exp=0", o_gate, o_trig); end
        total++; if (o_note !== '0 || o_velocity !== '0) begin bad++; $display("FAIL midrst_regs note=%h vel=%h exp=0", o_note, o_velocity); end
        total++; if (avs_s0_readdata !== '0) begin bad++; $display("FAIL midrst_rdata got=%h exp=0", avs_s0_readdata); end
        @(negedge clk);
        avs_s0_write = 1'b0;
        reset = 1'b1;
        model_reset();
        drive(1'b1, start_cmd(90, 3), 1'b0);
        total++; if (o_gate !== 8'h01 || o_note[6:0] !== 7'd90) begin bad++; $display("FAIL midrst_after gate=%h note=%0d exp=01/90", o_gate, o_note[6:0]); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_start();
        test_retrigger();
        test_stop();
        test_full_bank();
        test_lowest_free();
        test_stop_all();
        test_random();
`ifndef VOICE_ALLOC_STEAL_EN
        test_drop_saturate();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
